// File: rtl/itrace_block_decoder_pkg.sv
// Shared types and address helpers for the E-Trace block decoder.
// The optional contiguity checker is enabled by defining ITRACE_DECODER_CHECK_EN.
package itrace_block_decoder_pkg;

  localparam int XLEN        = 32;
  localparam int IRETIRE_LEN = 14;
  localparam int ITYPE_LEN   = 3;
  localparam int PRIV_LEN    = 2;

  localparam logic [ITYPE_LEN-1:0] ITYPE_NONE = 3'd0;
  localparam logic [ITYPE_LEN-1:0] ITYPE_EXC  = 3'd1;
  localparam logic [ITYPE_LEN-1:0] ITYPE_INT  = 3'd2;
  localparam logic [ITYPE_LEN-1:0] ITYPE_ERET = 3'd3;
  localparam logic [ITYPE_LEN-1:0] ITYPE_NTBR = 3'd4;
  localparam logic [ITYPE_LEN-1:0] ITYPE_TBR  = 3'd5;
  localparam logic [ITYPE_LEN-1:0] ITYPE_UJMP = 3'd6;

  typedef enum logic {IDLE, EMIT} decoder_state_e;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
  } itrace_block_s;

  // iretire counts halfwords, so the byte span is iretire*2 (mod 2^XLEN)
  function automatic logic [XLEN-1:0] next_addr_f(input logic [XLEN-1:0]        iaddr,
                                                  input logic [IRETIRE_LEN-1:0] iretire);
    return iaddr + XLEN'({iretire, 1'b0});
  endfunction

  function automatic logic [XLEN-1:0] last_addr_f(input logic [XLEN-1:0]        iaddr,
                                                  input logic [IRETIRE_LEN-1:0] iretire,
                                                  input logic                   ilastsize);
    if (iretire == '0) return iaddr;
    return next_addr_f(iaddr, iretire) - (ilastsize ? XLEN'(4) : XLEN'(2));
  endfunction

endpackage

// File: rtl/itrace_block_decoder_if.sv
// Block-bundle input and serialized block stream between the trace source and the decoder.
interface itrace_block_decoder_if
  import itrace_block_decoder_pkg::*;
#(
  parameter int N = 1
) ();
  logic [N-1:0]                  valid_i;
  logic [N-1:0][IRETIRE_LEN-1:0] iretire_i;
  logic [N-1:0]                  ilastsize_i;
  logic [N-1:0][ITYPE_LEN-1:0]   itype_i;
  logic [N-1:0][XLEN-1:0]        iaddr_i;
  logic [XLEN-1:0]               cause_i;
  logic [XLEN-1:0]               tval_i;
  logic [PRIV_LEN-1:0]           priv_i;

  logic                          valid_o;
  logic                          ready_i;
  logic [IRETIRE_LEN-1:0]        iretire_o;
  logic                          ilastsize_o;
  logic [ITYPE_LEN-1:0]          itype_o;
  logic [XLEN-1:0]               iaddr_o;
  logic [PRIV_LEN-1:0]           priv_o;
  logic [XLEN-1:0]               cause_o;
  logic [XLEN-1:0]               tval_o;
  logic [XLEN-1:0]               last_addr_o;
  logic [XLEN-1:0]               next_addr_o;
  logic                          overflow_o;
  logic                          discont_err_o;

  modport master (
    output valid_i, iretire_i, ilastsize_i, itype_i, iaddr_i, cause_i, tval_i, priv_i, ready_i,
    input  valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o, priv_o, cause_o, tval_o,
           last_addr_o, next_addr_o, overflow_o, discont_err_o
  );

  modport slave (
    input  valid_i, iretire_i, ilastsize_i, itype_i, iaddr_i, cause_i, tval_i, priv_i, ready_i,
    output valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o, priv_o, cause_o, tval_o,
           last_addr_o, next_addr_o, overflow_o, discont_err_o
  );
endinterface

// File: rtl/itrace_block_decoder_fifo.sv
// Synchronous FIFO (fifo_v3 style) with combinational head; push+pop when full is legal.
module itrace_block_decoder_fifo #(
  parameter int  DEPTH = 16,
  parameter type dtype = logic,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  dtype      data_i,
  input  logic      pop_i,
  output dtype      data_o,
  output logic      full_o,
  output logic [AW:0] usage_o
);
  dtype        mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   cnt_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/itrace_block_decoder.sv
// Buffers up to N retirement blocks per cycle and replays them one per cycle with address math.
// Defining ITRACE_DECODER_CHECK_EN adds the address-contiguity checker on discont_err_o.
module itrace_block_decoder
  import itrace_block_decoder_pkg::*;
#(
  parameter int N          = 1,
  parameter int FIFO_DEPTH = 16
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  itrace_block_decoder_if.slave bus
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  typedef struct packed {
    logic [N-1:0]          valid;
    itrace_block_s [N-1:0] block;
    logic [XLEN-1:0]       cause;
    logic [XLEN-1:0]       tval;
    logic [PRIV_LEN-1:0]   priv;
  } itrace_bundle_s;

  itrace_bundle_s   in_bundle, head;
  itrace_block_s    blk;
  decoder_state_e   state_q;
  logic [IDX_W-1:0] slot_q, cur_slot, next_slot;
  logic [CNT_W-1:0] usage;
  logic [XLEN-1:0]  next_addr, last_addr;
  logic             full, push, pop, xfer, vld, has_next, overflow_q;

  always_comb begin
    in_bundle.valid = bus.valid_i;
    in_bundle.cause = bus.cause_i;
    in_bundle.tval  = bus.tval_i;
    in_bundle.priv  = bus.priv_i;
    for (int i = 0; i < N; i++) begin
      in_bundle.block[i].iretire   = bus.iretire_i[i];
      in_bundle.block[i].ilastsize = bus.ilastsize_i[i];
      in_bundle.block[i].itype     = bus.itype_i[i];
      in_bundle.block[i].iaddr     = bus.iaddr_i[i];
    end
  end

  itrace_block_decoder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .dtype (itrace_bundle_s)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (in_bundle),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .usage_o (usage)
  );

  // Descending scans leave the lowest qualifying slot in each result
  always_comb begin
    cur_slot  = '0;
    next_slot = '0;
    has_next  = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (head.valid[i] && i >= int'(slot_q)) cur_slot = IDX_W'(i);
    for (int i = N - 1; i >= 0; i--)
      if (head.valid[i] && i > int'(cur_slot)) begin
        next_slot = IDX_W'(i);
        has_next  = 1'b1;
      end
  end

  assign blk       = head.block[cur_slot];
  assign next_addr = next_addr_f(blk.iaddr, blk.iretire);
  assign last_addr = last_addr_f(blk.iaddr, blk.iretire, blk.ilastsize);

  assign vld  = (state_q == EMIT);
  assign xfer = vld && bus.ready_i;
  assign pop  = xfer && !has_next;
  assign push = (|bus.valid_i) && (!full || pop);

  assign bus.valid_o     = vld;
  assign bus.iretire_o   = vld ? blk.iretire   : '0;
  assign bus.ilastsize_o = vld ? blk.ilastsize : 1'b0;
  assign bus.itype_o     = vld ? blk.itype     : '0;
  assign bus.iaddr_o     = vld ? blk.iaddr     : '0;
  assign bus.priv_o      = vld ? head.priv     : '0;
  assign bus.next_addr_o = vld ? next_addr     : '0;
  assign bus.last_addr_o = vld ? last_addr     : '0;
  assign bus.cause_o     = (vld && (blk.itype == ITYPE_EXC || blk.itype == ITYPE_INT)) ? head.cause : '0;
  assign bus.tval_o      = (vld && (blk.itype == ITYPE_EXC || blk.itype == ITYPE_INT)) ? head.tval  : '0;
  assign bus.overflow_o  = overflow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if ((|bus.valid_i) && full && !pop) overflow_q <= 1'b1;
      case (state_q)
        IDLE: if (push) state_q <= EMIT;
        EMIT: if (xfer) begin
          if (has_next) begin
            slot_q <= next_slot;
          end else begin
            slot_q <= '0;
            if (usage == CNT_W'(1) && !push) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ITRACE_DECODER_CHECK_EN
  logic                 have_rec_q;
  logic [XLEN-1:0]      rec_next_q;
  logic [ITYPE_LEN-1:0] rec_type_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   have_rec_q <= 1'b0;
    else if (xfer) have_rec_q <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (xfer) begin
      rec_next_q <= next_addr;
      rec_type_q <= blk.itype;
    end
  end

  // Only sequential (none) and not-taken-branch endings promise a contiguous successor
  assign bus.discont_err_o = xfer && have_rec_q &&
                             (rec_type_q == ITYPE_NONE || rec_type_q == ITYPE_NTBR) &&
                             (blk.iaddr != rec_next_q);
`else
  assign bus.discont_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_itrace_block_decoder.sv
// Scoreboard bench for itrace_block_decoder (N=2, small FIFO); adapts to ITRACE_DECODER_CHECK_EN.
module tb_itrace_block_decoder;
  import itrace_block_decoder_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  itrace_block_decoder_if #(.N(N)) bus ();

  itrace_block_decoder #(.N(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] iaddr, next, last, cause, tval;
    logic [13:0] iretire;
    logic        ils;
    logic [2:0]  itype;
    logic [1:0]  priv;
  } exp_t;

  exp_t        exp_q[$];
  int          bq[$];
  int          checks   = 0;
  int          failures = 0;
  bit          ovf_m    = 1'b0;
  bit          have_rec = 1'b0;
  logic [31:0] rec_next;
  logic [2:0]  rec_type;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sampled mid-cycle, compares head, retires on ready, then accepts pushes
  always @(negedge clk_i) begin
    exp_t e;
    int   n;
    bit   pop_now, err_m;
    if (!rst_ni) begin
      check_eq("rst_valid", 64'(bus.valid_o), 64'(0));
      check_eq("rst_ovf", 64'(bus.overflow_o), 64'(0));
      check_eq("rst_disc", 64'(bus.discont_err_o), 64'(0));
      exp_q.delete();
      bq.delete();
      ovf_m    = 1'b0;
      have_rec = 1'b0;
    end else begin
      pop_now = 1'b0;
      err_m   = 1'b0;
      check_eq("valid", 64'(bus.valid_o), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check_eq("iaddr", 64'(bus.iaddr_o), 64'(e.iaddr));
        check_eq("iretire", 64'(bus.iretire_o), 64'(e.iretire));
        check_eq("ilastsize", 64'(bus.ilastsize_o), 64'(e.ils));
        check_eq("itype", 64'(bus.itype_o), 64'(e.itype));
        check_eq("priv", 64'(bus.priv_o), 64'(e.priv));
        check_eq("cause", 64'(bus.cause_o), 64'(e.cause));
        check_eq("tval", 64'(bus.tval_o), 64'(e.tval));
        check_eq("next_addr", 64'(bus.next_addr_o), 64'(e.next));
        check_eq("last_addr", 64'(bus.last_addr_o), 64'(e.last));
        if (bus.ready_i) begin
          void'(exp_q.pop_front());
          bq[0] = bq[0] - 1;
          if (bq[0] == 0) begin
            void'(bq.pop_front());
            pop_now = 1'b1;
          end
`ifdef ITRACE_DECODER_CHECK_EN
          if (have_rec && (rec_type == 3'd0 || rec_type == 3'd4) && e.iaddr != rec_next) err_m = 1'b1;
          have_rec = 1'b1;
          rec_next = e.next;
          rec_type = e.itype;
`endif
        end
      end
      check_eq("discont", 64'(bus.discont_err_o), 64'(err_m));
      check_eq("overflow", 64'(bus.overflow_o), 64'(ovf_m));
      if (|bus.valid_i) begin
        if ((bq.size() - int'(pop_now)) < DEPTH) begin
          n = 0;
          for (int s = 0; s < N; s++) begin
            if (bus.valid_i[s]) begin
              e.iaddr   = bus.iaddr_i[s];
              e.iretire = bus.iretire_i[s];
              e.ils     = bus.ilastsize_i[s];
              e.itype   = bus.itype_i[s];
              e.priv    = bus.priv_i;
              e.next    = e.iaddr + 32'(e.iretire) * 32'd2;
              e.last    = (e.iretire == 0) ? e.iaddr : e.next - (e.ils ? 32'd4 : 32'd2);
              e.cause   = (e.itype == 3'd1 || e.itype == 3'd2) ? bus.cause_i : 32'd0;
              e.tval    = (e.itype == 3'd1 || e.itype == 3'd2) ? bus.tval_i  : 32'd0;
              exp_q.push_back(e);
              n++;
            end
          end
          bq.push_back(n);
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic set_blk(input int s, input logic [31:0] a, input int r, input logic ls,
                         input logic [2:0] t);
    bus.iaddr_i[s]     = a;
    bus.iretire_i[s]   = 14'(r);
    bus.ilastsize_i[s] = ls;
    bus.itype_i[s]     = t;
  endtask

  task automatic push(input logic [N-1:0] v);
    bus.valid_i = v;
    cyc();
    bus.valid_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.valid_i     = '0;
    bus.iretire_i   = '0;
    bus.ilastsize_i = '0;
    bus.itype_i     = '0;
    bus.iaddr_i     = '0;
    bus.cause_i     = '0;
    bus.tval_i      = '0;
    bus.priv_i      = '0;
    bus.ready_i     = 1'b1;
    cyc(3);
    rst_ni = 1'b1;
    cyc(2);

    // single block, first presented the cycle after the push
    bus.priv_i = 2'd3;
    set_blk(0, 32'h8000_0000, 6, 1'b1, 3'd5);
    push(2'b01);
    cyc(2);

    // two slots in one bundle, slot 0 carries an exception
    bus.cause_i = 32'h0000_0005;
    bus.tval_i  = 32'h0000_dead;
    set_blk(0, 32'h0000_1000, 3, 1'b0, 3'd1);
    set_blk(1, 32'h0000_1006, 2, 1'b1, 3'd4);
    push(2'b11);
    cyc(3);

    // hole in slot 0, then wrap-around and zero-retire blocks
    bus.priv_i = 2'd1;
    set_blk(1, 32'h0000_2000, 5, 1'b0, 3'd6);
    push(2'b10);
    set_blk(0, 32'hFFFF_FFFC, 4, 1'b0, 3'd6);
    set_blk(1, 32'h0000_0040, 0, 1'b1, 3'd3);
    push(2'b11);
    cyc(4);

    // back-pressure: block held for five cycles, then one transfer
    bus.ready_i = 1'b0;
    set_blk(0, 32'h0000_3000, 7, 1'b1, 3'd2);
    push(2'b01);
    cyc(5);
    bus.ready_i = 1'b1;
    cyc(3);

    // fill past capacity, then push while popping from a full FIFO
    bus.ready_i = 1'b0;
    for (int k = 0; k <= DEPTH; k++) begin
      set_blk(0, 32'h0000_4000 + 32'(k) * 32'h10, k + 1, k[0], 3'd5);
      set_blk(1, 32'h0000_6000 + 32'(k) * 32'h10, 2, 1'b1, 3'd6);
      push((k == 0) ? 2'b01 : ((k % 3 == 1) ? 2'b11 : 2'b10));
    end
    cyc(2);
    bus.ready_i = 1'b1;
    set_blk(0, 32'h0000_5000, 2, 1'b0, 3'd5);
    push(2'b01);
    cyc(3 * DEPTH + 4);

    // contiguity: not-taken branch followed by a mismatching address, then permitted and matching cases
    set_blk(0, 32'h0000_00F8, 4, 1'b1, 3'd4);
    set_blk(1, 32'h0000_0104, 2, 1'b0, 3'd0);
    push(2'b11);
    cyc(3);
    set_blk(0, 32'h0000_00F8, 4, 1'b1, 3'd5);
    set_blk(1, 32'h0000_0104, 2, 1'b0, 3'd5);
    push(2'b11);
    cyc(3);
    set_blk(0, 32'h0000_00F8, 4, 1'b1, 3'd0);
    set_blk(1, 32'h0000_0100, 2, 1'b0, 3'd0);
    push(2'b11);
    cyc(3);

    // reset while bundles are queued; first block afterwards is exempt from the check
    set_blk(0, 32'h0000_01F8, 4, 1'b1, 3'd4);
    push(2'b01);
    cyc(2);
    bus.ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_blk(0, 32'h0000_7000 + 32'(k) * 32'h20, 3, 1'b0, 3'd0);
      push(2'b01);
    end
    cyc();
    rst_ni = 1'b0;
    #1;
    check_eq("rst_async_valid", 64'(bus.valid_o), 64'(0));
    cyc(2);
    rst_ni      = 1'b1;
    bus.ready_i = 1'b1;
    set_blk(0, 32'h0000_0300, 1, 1'b0, 3'd0);
    push(2'b01);
    cyc(2);
    set_blk(0, 32'h0000_0400, 2, 1'b1, 3'd0);
    push(2'b01);
    cyc(4);
    check_eq("drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
